ex_cond_stage: RTL and testbench
================================

// Module: ex_cond_stage
// PURPOSE
//   Execute-stage back end. Sits directly downstream of the ALU. Owns the architectural
//   CPSR flags (NZCV), which it feeds back to the ALU cpsr input. Evaluates each
//   instruction's ARM condition field against those flags, commits the ALU flag update
//   only for executed flag-setting instructions, and registers the result into the
//   EX/MEM pipeline latch, with stall and flush.
// PARAMETERS
//   CNT_W    16   width of the saturating annulled-instruction counter
//   RST_CPSR 4'h0 reset value of the NZCV flags
// PORTS
//   clk_i          in   1   clock; all state updates on the rising edge
//   reset_i        in   1   asynchronous, active-high reset
//   stall_i        in   1   hold EX/MEM latch, CPSR and counter
//   flush_i        in   1   kill the instruction currently in EX
//   valid_i        in   1   EX holds a real instruction
//   cond_i         in   4   instruction condition field [31:28]
//   set_flags_i    in   1   S bit; ALU-compare ops also assert it
//   alu_out_i      in   32  ALU result
//   cpsr_update_i  in   4   ALU flags {N,Z,C,V}
//   store_data_i   in   32  Rd value for STR
//   rd_i           in   4   destination register
//   reg_write_i    in   1   writes Rd
//   mem_read_i     in   1   load
//   mem_write_i    in   1   store
//   cpsr_o         out  4   current flags {N,Z,C,V}; drives ALU cpsr input
//   cond_pass_o    out  1   comb: cond_i satisfied by cpsr_o
//   valid_o        out  1   EX/MEM holds an executed instruction
//   alu_out_o      out  32  latched result / memory address
//   store_data_o   out  32  latched store data
//   rd_o           out  4   latched destination
//   reg_write_o    out  1   latched, gated write enable
//   mem_read_o     out  1   latched, gated load
//   mem_write_o    out  1   latched, gated store
//   annul_cnt_o    out  CNT_W  saturating count of condition-failed instructions
// BEHAVIOUR
//   - Reset (async, immediate): cpsr_o=RST_CPSR. All latch outputs and annul_cnt_o = 0.
//   - cond_pass_o is combinational from cond_i and cpsr_o:
//       EQ Z;  NE !Z;  CS C;  CC !C;  MI N;  PL !N;  VS V;  VC !V;
//       HI C&!Z;  LS !C|Z;  GE N==V;  LT N!=V;  GT !Z&(N==V);  LE Z|(N!=V);  AL 1;  1111 0.
//   - exec = valid_i & cond_pass_o.
//   - Per edge, in priority order:
//       flush_i: valid_o, reg_write_o, mem_read_o, mem_write_o <- 0.
//                CPSR and counter are not updated. Data fields are don't-care.
//                flush_i wins over stall_i.
//       stall_i: every register holds its value.
//       else:    latch alu_out_i, store_data_i and rd_i. valid_o <- exec.
//                reg_write_o <- reg_write_i & exec; mem_read_o and mem_write_o likewise.
//                If exec & set_flags_i: cpsr_o <- cpsr_update_i.
//                If valid_i & !cond_pass_o: annul_cnt_o <- annul_cnt_o + 1, saturating
//                at all ones.
//   - Latency: 1 cycle EX->MEM. A flag-setting instruction's flags are visible on
//     cpsr_o, and to the next instruction's condition check, the cycle after it leaves EX.
//   - valid_i=0: behaves as a bubble. Nothing is committed, even with set_flags_i or
//     reg_write_i high.
//   - A failed condition yields a bubble in MEM; the data fields are still latched.
// STRUCTURE
//   - Shared include arm_defs.vh: COND_EQ..COND_NV localparams and the NZCV bit indices
//     (N=3, Z=2, C=1, V=0), which the ALU uses too.
//   - One combinational sub-module, cond_check (cond[3:0], nzcv[3:0] -> pass). Reused by
//     the branch unit.
//   - Remaining logic: CPSR register, EX/MEM latch, counter.
// TESTING
//   - Reset: assert reset_i mid-cycle -> all outputs 0 at once; cpsr_o=RST_CPSR.
//   - Flag commit: CMP (set_flags_i=1, cpsr_update_i=4'b0110, cond AL) -> next cycle
//     cpsr_o=4'b0110; following BEQ-style cond 0000 gives cond_pass_o=1, cond 0001 gives 0.
//   - Annul: cpsr_o Z=0, ADDEQ with reg_write_i=1 and set_flags_i=1 -> valid_o=0,
//     reg_write_o=0, cpsr_o unchanged, annul_cnt_o +1.
//   - Stall/flush: stall_i=1 for 3 cycles -> outputs and cpsr_o frozen. flush_i=1 with
//     stall_i=1 and a flag-setting instruction -> valid_o=0, cpsr_o unchanged.
//   - Full condition table: sweep all 16 cond_i x 16 NZCV values -> cond_pass_o matches
//     the table above (256 checks). cond 1111 never passes.
//   - Saturation: preload the counter near all ones and feed continuous failing
//     instructions -> holds at 2**CNT_W-1 and does not wrap to 0.

Source files
------------

// File: rtl/ex_cond_stage_pkg.sv
// ex_cond_stage_pkg
//   Shared ARM definitions for the execute stage: condition-field encodings
//   and the NZCV bit positions inside the 4-bit flag vector {N,Z,C,V}.
//   The ALU and the branch unit use the same constants.
package ex_cond_stage_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/ex_cond_stage_cond_check.sv
// ex_cond_stage_cond_check
//   Combinational ARM condition evaluator.
//   Ports:
//     cond  in  4  instruction condition field [31:28]
//     nzcv  in  4  flags {N,Z,C,V}
//     pass  out 1  condition satisfied
module ex_cond_stage_cond_check
    import ex_cond_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;   // NV never executes
        endcase
    end

endmodule

// File: rtl/ex_cond_stage.sv
// ex_cond_stage
//   Execute-stage back end. Holds the architectural NZCV flags, evaluates the
//   condition field of the instruction in EX, commits ALU flags for executed
//   flag-setting instructions and registers the result into the EX/MEM latch.
//   Ports:
//     clk_i, reset_i (async, active high)
//     stall_i, flush_i          pipeline control (flush wins)
//     valid_i, cond_i, set_flags_i, alu_out_i, cpsr_update_i,
//     store_data_i, rd_i, reg_write_i, mem_read_i, mem_write_i   EX inputs
//     cpsr_o, cond_pass_o       current flags / combinational condition result
//     valid_o, alu_out_o, store_data_o, rd_o,
//     reg_write_o, mem_read_o, mem_write_o                      EX/MEM latch
//     annul_cnt_o               saturating count of condition-failed instructions
module ex_cond_stage
    import ex_cond_stage_pkg::*;
#(
    parameter int         CNT_W    = 16,
    parameter logic [3:0] RST_CPSR = 4'h0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [3:0]       cond_i,
    input  logic             set_flags_i,
    input  logic [31:0]      alu_out_i,
    input  logic [3:0]       cpsr_update_i,
    input  logic [31:0]      store_data_i,
    input  logic [3:0]       rd_i,
    input  logic             reg_write_i,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    output logic [3:0]       cpsr_o,
    output logic             cond_pass_o,
    output logic             valid_o,
    output logic [31:0]      alu_out_o,
    output logic [31:0]      store_data_o,
    output logic [3:0]       rd_o,
    output logic             reg_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic [CNT_W-1:0] annul_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic exec;
    logic annul;

    ex_cond_stage_cond_check u_cond_check (
        .cond (cond_i),
        .nzcv (cpsr_o),
        .pass (cond_pass_o)
    );

    assign exec  = valid_i & cond_pass_o;
    assign annul = valid_i & ~cond_pass_o;

    // CPSR and annul counter: frozen on flush as well as stall, so a killed
    // instruction can never leave architectural side effects.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cpsr_o      <= RST_CPSR;
            annul_cnt_o <= '0;
        end else if (!flush_i && !stall_i) begin
            if (exec && set_flags_i)
                cpsr_o <= cpsr_update_i;
            if (annul && (annul_cnt_o != '1))
                annul_cnt_o <= annul_cnt_o + CNT_ONE;
        end
    end

    // EX/MEM latch. Data fields are latched even for an annulled instruction;
    // only the control bits are gated by exec.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_o      <= 1'b0;
            alu_out_o    <= '0;
            store_data_o <= '0;
            rd_o         <= '0;
            reg_write_o  <= 1'b0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
        end else if (flush_i) begin
            valid_o      <= 1'b0;
            reg_write_o  <= 1'b0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
        end else if (!stall_i) begin
            valid_o      <= exec;
            alu_out_o    <= alu_out_i;
            store_data_o <= store_data_i;
            rd_o         <= rd_i;
            reg_write_o  <= reg_write_i & exec;
            mem_read_o   <= mem_read_i & exec;
            mem_write_o  <= mem_write_i & exec;
        end
    end

endmodule

// File: tb/tb_ex_cond_stage.sv
// tb_ex_cond_stage
//   Directed testbench for ex_cond_stage. A narrow counter width is used so
//   saturation can be reached in a few cycles.
module tb_ex_cond_stage;

    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          stall_i, flush_i, valid_i, set_flags_i;
    logic [3:0]    cond_i, cpsr_update_i, rd_i;
    logic [31:0]   alu_out_i, store_data_i;
    logic          reg_write_i, mem_read_i, mem_write_i;
    logic [3:0]    cpsr_o, rd_o;
    logic          cond_pass_o, valid_o, reg_write_o, mem_read_o, mem_write_o;
    logic [31:0]   alu_out_o, store_data_o;
    logic [CW-1:0] annul_cnt_o;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    ex_cond_stage #(.CNT_W(CW), .RST_CPSR(4'h0)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .valid_i       (valid_i),
        .cond_i        (cond_i),
        .set_flags_i   (set_flags_i),
        .alu_out_i     (alu_out_i),
        .cpsr_update_i (cpsr_update_i),
        .store_data_i  (store_data_i),
        .rd_i          (rd_i),
        .reg_write_i   (reg_write_i),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .cpsr_o        (cpsr_o),
        .cond_pass_o   (cond_pass_o),
        .valid_o       (valid_o),
        .alu_out_o     (alu_out_o),
        .store_data_o  (store_data_o),
        .rd_o          (rd_o),
        .reg_write_o   (reg_write_o),
        .mem_read_o    (mem_read_o),
        .mem_write_o   (mem_write_o),
        .annul_cnt_o   (annul_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference condition table written from the ARM definition.
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic sf,
                         input logic [3:0] upd, input logic [31:0] alu,
                         input logic rw, input logic mr, input logic mw);
        valid_i       = v;
        cond_i        = c;
        set_flags_i   = sf;
        cpsr_update_i = upd;
        alu_out_i     = alu;
        store_data_i  = ~alu;
        rd_i          = alu[3:0];
        reg_write_i   = rw;
        mem_read_i    = mr;
        mem_write_i   = mw;
    endtask

    initial begin
        reset_i = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #12;
        reset_i = 1'b0;
        check("rst_cpsr", {28'd0, cpsr_o}, 32'h0);
        check("rst_valid", {31'd0, valid_o}, 32'h0);
        check("rst_cnt", {28'd0, annul_cnt_o}, 32'h0);
        check("rst_alu", alu_out_o, 32'h0);

        // CMP-like flag setter, cond AL
        @(posedge clk_i); #1;
        drive(1'b1, 4'd14, 1'b1, 4'b0110, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
        tick();
        check("cmp_cpsr", {28'd0, cpsr_o}, 32'h6);
        check("cmp_valid", {31'd0, valid_o}, 32'h1);
        check("cmp_alu", alu_out_o, 32'h0000_1234);
        check("cmp_store", store_data_o, 32'hFFFF_EDCB);
        check("cmp_rd", {28'd0, rd_o}, 32'h4);
        check("cmp_rw", {31'd0, reg_write_o}, 32'h1);
        drive(1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("beq_pass", {31'd0, cond_pass_o}, 32'h1);
        cond_i = 4'd1;
        #1;
        check("bne_pass", {31'd0, cond_pass_o}, 32'h0);

        // asynchronous reset in mid-cycle
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_cpsr", {28'd0, cpsr_o}, 32'h0);
        check("arst_valid", {31'd0, valid_o}, 32'h0);
        check("arst_rw", {31'd0, reg_write_o}, 32'h0);
        check("arst_alu", alu_out_o, 32'h0);
        check("arst_rd", {28'd0, rd_o}, 32'h0);
        #1;
        reset_i = 1'b0;
        exp_cnt = 0;

        // ADDEQ with Z=0: annulled
        @(posedge clk_i); #1;
        drive(1'b1, 4'd0, 1'b1, 4'b1111, 32'h0000_00A7, 1'b1, 1'b0, 1'b1);
        tick();
        exp_cnt++;
        check("ann_valid", {31'd0, valid_o}, 32'h0);
        check("ann_rw", {31'd0, reg_write_o}, 32'h0);
        check("ann_mw", {31'd0, mem_write_o}, 32'h0);
        check("ann_cpsr", {28'd0, cpsr_o}, 32'h0);
        check("ann_cnt", {28'd0, annul_cnt_o}, 32'(exp_cnt));
        check("ann_alu", alu_out_o, 32'h0000_00A7);

        // bubble with set_flags and reg_write high
        drive(1'b0, 4'd14, 1'b1, 4'b1010, 32'h0000_0011, 1'b1, 1'b1, 1'b1);
        tick();
        check("bub_valid", {31'd0, valid_o}, 32'h0);
        check("bub_rw", {31'd0, reg_write_o}, 32'h0);
        check("bub_mr", {31'd0, mem_read_o}, 32'h0);
        check("bub_cpsr", {28'd0, cpsr_o}, 32'h0);
        check("bub_cnt", {28'd0, annul_cnt_o}, 32'(exp_cnt));

        // executed load with flags -> then stall for 3 cycles
        drive(1'b1, 4'd14, 1'b1, 4'b1000, 32'h0000_0055, 1'b0, 1'b1, 1'b0);
        tick();
        check("ld_cpsr", {28'd0, cpsr_o}, 32'h8);
        check("ld_mr", {31'd0, mem_read_o}, 32'h1);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, (i % 2 == 0) ? 4'd0 : 4'd14, 1'b1, 4'b0011,
                  32'h0000_0099 + i, 1'b1, 1'b0, 1'b1);
            tick();
            check("stl_alu", alu_out_o, 32'h0000_0055);
            check("stl_cpsr", {28'd0, cpsr_o}, 32'h8);
            check("stl_valid", {31'd0, valid_o}, 32'h1);
            check("stl_mw", {31'd0, mem_write_o}, 32'h0);
            check("stl_cnt", {28'd0, annul_cnt_o}, 32'(exp_cnt));
        end

        // flush beats stall, flags not committed
        flush_i = 1'b1;
        drive(1'b1, 4'd14, 1'b1, 4'b0101, 32'h0000_0077, 1'b1, 1'b0, 1'b0);
        tick();
        check("fl_valid", {31'd0, valid_o}, 32'h0);
        check("fl_rw", {31'd0, reg_write_o}, 32'h0);
        check("fl_mr", {31'd0, mem_read_o}, 32'h0);
        check("fl_cpsr", {28'd0, cpsr_o}, 32'h8);
        stall_i = 1'b0;
        drive(1'b1, 4'd0, 1'b0, 4'd0, 32'h0000_0078, 1'b0, 1'b0, 1'b0);
        tick();
        check("fl_cnt", {28'd0, annul_cnt_o}, 32'(exp_cnt));
        flush_i = 1'b0;

        // full condition table
        for (int f = 0; f < 16; f++) begin
            drive(1'b1, 4'd14, 1'b1, 4'(f), 32'(f), 1'b0, 1'b0, 1'b0);
            tick();
            check("sw_cpsr", {28'd0, cpsr_o}, 32'(f));
            drive(1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++) begin
                cond_i = 4'(c);
                #1;
                check($sformatf("cond_%0d_%0d", c, f), {31'd0, cond_pass_o},
                      {31'd0, cond_model(4'(c), 4'(f))});
            end
        end

        // saturation with continuous NV instructions
        @(posedge clk_i); #1;
        drive(1'b1, 4'd15, 1'b1, 4'b0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (exp_cnt < (1 << CW) - 1) exp_cnt++;
            check("sat_cnt", {28'd0, annul_cnt_o}, 32'(exp_cnt));
        end
        check("sat_final", {28'd0, annul_cnt_o}, 32'hF);
        check("sat_cpsr", {28'd0, cpsr_o}, 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
